// File: rtl/clock_mon_pkg.sv
// Shared types and helpers for the clock_mon frequency/lock monitor.
package clock_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_TRACK  = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    // |period - nominal| <= tol, computed without wrapping the subtraction
    function automatic logic period_ok(input logic [31:0] period,
                                       input logic [31:0] nominal,
                                       input logic [31:0] tol);
        logic [31:0] diff;
        diff = (period >= nominal) ? (period - nominal) : (nominal - period);
        return diff <= tol;
    endfunction

endpackage

// File: rtl/clock_mon_edge_sync.sv
// Synchronizer and registered rising-edge pulse for the monitored clock.
// CLOCK_MON_DEGLITCH_EN: accept an edge only after two consecutive high samples.
module clock_mon_edge_sync (
    input  logic i_clk50mhz,
    input  logic i_rst_n,
    input  logic i_clk_mon,
    output logic o_edge
);

    logic sync_p0;
    logic sync_p1;
    logic hist_p2;
`ifdef CLOCK_MON_DEGLITCH_EN
    logic hist_p3;
`endif

    always_ff @(posedge i_clk50mhz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            hist_p2 <= 1'b0;
`ifdef CLOCK_MON_DEGLITCH_EN
            hist_p3 <= 1'b0;
`endif
            o_edge  <= 1'b0;
        end else begin
            // synchronizer -> history -> registered edge pulse
            sync_p0 <= i_clk_mon;
            sync_p1 <= sync_p0;
            hist_p2 <= sync_p1;
`ifdef CLOCK_MON_DEGLITCH_EN
            hist_p3 <= hist_p2;
            o_edge  <= sync_p1 & hist_p2 & ~hist_p3;
`else
            o_edge  <= sync_p1 & ~hist_p2;
`endif
        end
    end

endmodule

// File: rtl/clock_mon.sv
// Period/lock monitor for a slow asynchronous clock, measured in i_clk50mhz cycles.
// Optional macro CLOCK_MON_DEGLITCH_EN enables single-cycle glitch rejection in the edge detector.
module clock_mon
    import clock_mon_pkg::*;
#(
    parameter int P_NOMINAL  = 10,
    parameter int P_TOL      = 1,
    parameter int P_LOCK_CNT = 4,
    parameter int P_TIMEOUT  = 32,
    parameter int P_CW       = 8
) (
    input  logic            i_clk50mhz,
    input  logic            i_rst_n,
    input  logic            i_clk_mon,
    input  logic            i_enable,
    input  logic            i_clear,
    output logic [P_CW-1:0] o_period,
    output logic            o_period_valid,
    output logic            o_locked,
    output logic            o_lost
);

    localparam logic [P_CW-1:0] TIMEOUT_C = P_CW'(P_TIMEOUT);
    localparam logic [P_CW-1:0] LOCK_C    = P_CW'(P_LOCK_CNT);

    function automatic logic [P_CW-1:0] sat_inc(input logic [P_CW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic            edge_p3;
    state_t          state, state_nxt;
    logic [P_CW-1:0] r_cnt, cnt_nxt;
    logic [P_CW-1:0] good_cnt, good_nxt;
    logic [P_CW-1:0] period_meas;
    logic            in_tol;
    logic            upd;
    logic            lost_set;

    clock_mon_edge_sync u_edge_sync (
        .i_clk50mhz (i_clk50mhz),
        .i_rst_n    (i_rst_n),
        .i_clk_mon  (i_clk_mon),
        .o_edge     (edge_p3)
    );

    assign period_meas = sat_inc(r_cnt);
    assign in_tol      = period_ok(32'(period_meas), 32'(P_NOMINAL), 32'(P_TOL));
    assign o_locked    = (state == ST_LOCKED);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = sat_inc(r_cnt);
        good_nxt  = good_cnt;
        upd       = 1'b0;
        lost_set  = 1'b0;
        if (!i_enable) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            good_nxt  = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt_nxt   = '0;
                    good_nxt  = '0;
                    state_nxt = ST_SYNC;
                end
                ST_SYNC: begin
                    // first edge only aligns the counter; that period is partial
                    if (edge_p3) begin
                        cnt_nxt   = '0;
                        good_nxt  = '0;
                        state_nxt = ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (edge_p3) begin
                        cnt_nxt = '0;
                        upd     = 1'b1;
                        if (in_tol) begin
                            good_nxt = good_cnt + 1'b1;
                            if (good_cnt + 1'b1 >= LOCK_C) state_nxt = ST_LOCKED;
                        end else begin
                            good_nxt = '0;
                        end
                    end else if (r_cnt >= TIMEOUT_C) begin
                        good_nxt  = '0;
                        state_nxt = ST_SYNC;
                    end
                end
                ST_LOCKED: begin
                    if (edge_p3) begin
                        cnt_nxt = '0;
                        upd     = 1'b1;
                        if (!in_tol) begin
                            good_nxt  = '0;
                            lost_set  = 1'b1;
                            state_nxt = ST_TRACK;
                        end
                    end else if (r_cnt >= TIMEOUT_C) begin
                        good_nxt  = '0;
                        lost_set  = 1'b1;
                        state_nxt = ST_SYNC;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk50mhz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= ST_IDLE;
            r_cnt          <= '0;
            good_cnt       <= '0;
            o_period       <= '0;
            o_period_valid <= 1'b0;
            o_lost         <= 1'b0;
        end else begin
            state          <= state_nxt;
            r_cnt          <= cnt_nxt;
            good_cnt       <= good_nxt;
            o_period_valid <= upd;
            if (upd) o_period <= period_meas;
            // a set in the same cycle as a clear takes priority
            o_lost         <= lost_set | (o_lost & ~i_clear);
        end
    end

endmodule

// File: tb/tb_clock_mon.sv
// Scoreboard bench for clock_mon: directed monitored-clock waveforms, strobes checked by a monitor.
module tb_clock_mon;

    logic       clk;
    logic       rst_n;
    logic       mon;
    logic       en;
    logic       clr;
    logic [7:0] o_period;
    logic       o_period_valid;
    logic       o_locked;
    logic       o_lost;

    typedef struct {
        int per;
        bit lk;
        bit ls;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    clock_mon dut (
        .i_clk50mhz     (clk),
        .i_rst_n        (rst_n),
        .i_clk_mon      (mon),
        .i_enable       (en),
        .i_clear        (clr),
        .o_period       (o_period),
        .o_period_valid (o_period_valid),
        .o_locked       (o_locked),
        .o_lost         (o_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
        end
    endfunction

    // Monitor: every strobe must match the next queued expectation
    always @(negedge clk) begin
        if (rst_n && o_period_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got period %0d expected no strobe (t=%0t)",
                         o_period, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("strobe_period", int'(o_period), mon_e.per);
                check("strobe_locked", int'(o_locked), int'(mon_e.lk));
                check("strobe_lost",   int'(o_lost),   int'(mon_e.ls));
            end
        end
    end

    // Rising edge now, high for hi cycles, low for lo cycles; optionally expect the strobe
    // reporting the interval this rise closes.
    task automatic mon_edge(input int hi, input int lo, input bit chk,
                            input int per, input bit lk, input bit ls);
        exp_t e;
        if (chk) begin
            e.per = per;
            e.lk  = lk;
            e.ls  = ls;
            exp_q.push_back(e);
        end
        mon = 1'b1;
        repeat (hi) @(negedge clk);
        mon = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic lock10(input bit ls);
        mon_edge(5, 5, 1'b0, 0, 1'b0, 1'b0);
        repeat (3) mon_edge(5, 5, 1'b1, 10, 1'b0, ls);
        mon_edge(5, 5, 1'b1, 10, 1'b1, ls);
    endtask

    task automatic pulse_clear();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int waited;
        rst_n = 1'b0;
        mon   = 1'b0;
        en    = 1'b0;
        clr   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_period", int'(o_period), 0);
        check("reset_valid",  int'(o_period_valid), 0);
        check("reset_locked", int'(o_locked), 0);
        check("reset_lost",   int'(o_lost), 0);
        rst_n = 1'b1;
        @(negedge clk);
        en = 1'b1;

        // period 12 never locks, period 11 locks after four good periods
        mon_edge(6, 6, 1'b0, 0, 1'b0, 1'b0);
        repeat (3) mon_edge(6, 6, 1'b1, 12, 1'b0, 1'b0);
        mon_edge(5, 6, 1'b1, 12, 1'b0, 1'b0);
        repeat (3) mon_edge(5, 6, 1'b1, 11, 1'b0, 1'b0);
        mon_edge(5, 5, 1'b1, 11, 1'b1, 1'b0);
        repeat (2) mon_edge(5, 5, 1'b1, 10, 1'b1, 1'b0);

        // dead clock: still locked ~30 cycles after the last rise, lost by ~40
        repeat (20) @(negedge clk);
        check("timeout_early_locked", int'(o_locked), 1);
        repeat (10) @(negedge clk);
        check("timeout_locked", int'(o_locked), 0);
        check("timeout_lost",   int'(o_lost), 1);
        pulse_clear();
        check("clear_lost", int'(o_lost), 0);

        // resync at the nominal period
        lock10(1'b0);
        check("locked_nominal", int'(o_locked), 1);

        // asynchronous reset while locked
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_period", int'(o_period), 0);
        check("async_rst_valid",  int'(o_period_valid), 0);
        check("async_rst_locked", int'(o_locked), 0);
        check("async_rst_lost",   int'(o_lost), 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        lock10(1'b0);

        // single short period while locked, then relock with lost sticky
        mon_edge(5, 2, 1'b1, 10, 1'b1, 1'b0);
        mon_edge(5, 5, 1'b1, 7, 1'b0, 1'b1);
        repeat (3) mon_edge(5, 5, 1'b1, 10, 1'b0, 1'b1);
        mon_edge(5, 5, 1'b1, 10, 1'b1, 1'b1);

        // disable: lock drops, lost and period retained, no strobes while idle
        en = 1'b0;
        repeat (2) @(negedge clk);
        check("disable_locked", int'(o_locked), 0);
        check("disable_lost",   int'(o_lost), 1);
        check("disable_period", int'(o_period), 10);
        repeat (2) mon_edge(5, 5, 1'b0, 0, 1'b0, 1'b0);
        pulse_clear();
        check("idle_clear_lost", int'(o_lost), 0);
        en = 1'b1;
        lock10(1'b0);

        // one-cycle glitch in the low phase
        mon_edge(5, 2, 1'b1, 10, 1'b1, 1'b0);
`ifdef CLOCK_MON_DEGLITCH_EN
        mon_edge(1, 2, 1'b0, 0, 1'b0, 1'b0);
        mon_edge(5, 5, 1'b1, 10, 1'b1, 1'b0);
        mon_edge(5, 5, 1'b1, 10, 1'b1, 1'b0);
`else
        mon_edge(1, 2, 1'b1, 7, 1'b0, 1'b1);
        mon_edge(5, 5, 1'b1, 3, 1'b0, 1'b1);
        mon_edge(5, 5, 1'b1, 10, 1'b0, 1'b1);
`endif

        waited = 0;
        while (exp_q.size() != 0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("drain_pending", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
